// File: rtl/cjb_alu_ctrl_defs.sv
// Shared definitions for the ALU sequencing controller: widths, FSM encodings,
// CNVZ bit positions and function-group codes.
package cjb_alu_ctrl_defs;

    localparam int DATA_W = 8;
    localparam int RA_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int CNVZ_C = 3;
    localparam int CNVZ_N = 2;
    localparam int CNVZ_V = 1;
    localparam int CNVZ_Z = 0;

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_SHIFT = 2'b10;
    localparam logic [1:0] GRP_CONST = 2'b11;

    function automatic logic [1:0] func_group(input logic [3:0] func);
        return func[3:2];
    endfunction

endpackage

// File: rtl/cjb_alu_ctrl_v_if.sv
// Bus bundle between the instruction source / ALU side and the controller.
interface cjb_alu_ctrl_v_if;
    import cjb_alu_ctrl_defs::*;

    logic              Instr_Valid;
    logic              Instr_Ready;
    logic [3:0]        Instr_Func;
    logic [RA_W-1:0]   Instr_Rd;
    logic [RA_W-1:0]   Instr_Rx;
    logic [RA_W-1:0]   Instr_Ry;
    logic [1:0]        Instr_K;
    logic              Reg_Load;
    logic [RA_W-1:0]   Reg_Load_Sel;
    logic [DATA_W-1:0] Reg_Load_Data;
    logic [RA_W-1:0]   Reg_Rd_Sel;
    logic [DATA_W-1:0] Reg_Rd_Data;
    logic [3:0]        Func_Sel;
    logic [DATA_W-1:0] Operand_X;
    logic [DATA_W-1:0] Operand_Y;
    logic [1:0]        Const_K;
    logic              cin;
    logic [DATA_W-1:0] ALU_Result;
    logic [3:0]        ALU_CNVZ;
    logic              Done_Valid;
    logic [DATA_W-1:0] Done_Result;
    logic [3:0]        Status_CNVZ;

    modport slave (
        input  Instr_Valid, Instr_Func, Instr_Rd, Instr_Rx, Instr_Ry, Instr_K,
        input  Reg_Load, Reg_Load_Sel, Reg_Load_Data, Reg_Rd_Sel,
        input  ALU_Result, ALU_CNVZ,
        output Instr_Ready, Reg_Rd_Data, Func_Sel, Operand_X, Operand_Y,
        output Const_K, cin, Done_Valid, Done_Result, Status_CNVZ
    );

    modport master (
        output Instr_Valid, Instr_Func, Instr_Rd, Instr_Rx, Instr_Ry, Instr_K,
        output Reg_Load, Reg_Load_Sel, Reg_Load_Data, Reg_Rd_Sel,
        output ALU_Result, ALU_CNVZ,
        input  Instr_Ready, Reg_Rd_Data, Func_Sel, Operand_X, Operand_Y,
        input  Const_K, cin, Done_Valid, Done_Result, Status_CNVZ
    );

endinterface

// File: rtl/cjb_regfile4x8_v.sv
// 4x8 register file: three combinational read ports, one synchronous write port.
module cjb_regfile4x8_v
    import cjb_alu_ctrl_defs::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              we_i,
    input  logic [RA_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RA_W-1:0]   rx_sel_i,
    input  logic [RA_W-1:0]   ry_sel_i,
    input  logic [RA_W-1:0]   dbg_sel_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic [DATA_W-1:0] ry_data_o,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] regs_q [4];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rx_data_o  = regs_q[rx_sel_i];
    assign ry_data_o  = regs_q[ry_sel_i];
    assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/cjb_alu_ctrl_v.sv
// Sequencing controller for the 8-bit combinational ALU: accept, execute for one
// cycle, write result and flags back, pulse done.
//   state | meaning
//   IDLE  | ready for an instruction; operands captured on acceptance
//   EXEC  | ALU inputs held; result and flags written at the closing edge
//   DONE  | Done_Valid pulse; back to IDLE next
module cjb_alu_ctrl_v
    import cjb_alu_ctrl_defs::*;
(
    input  logic               Clock,
    input  logic               Reset,
    cjb_alu_ctrl_v_if.slave    bus
);

    state_e            state_q, state_d;
    logic [3:0]        func_sel_q;
    logic [DATA_W-1:0] operand_x_q;
    logic [DATA_W-1:0] operand_y_q;
    logic [1:0]        const_k_q;
    logic [RA_W-1:0]   rd_q;
    logic [3:0]        status_q;
    logic [DATA_W-1:0] done_result_q;

    logic              instr_ready;
    logic              accept;
    logic              done_valid;
    logic              wr_en;
    logic [RA_W-1:0]   wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rx_data;
    logic [DATA_W-1:0] ry_data;

    cjb_regfile4x8_v u_regfile (
        .Clock      (Clock),
        .Reset      (Reset),
        .we_i       (wr_en),
        .waddr_i    (wr_addr),
        .wdata_i    (wr_data),
        .rx_sel_i   (bus.Instr_Rx),
        .ry_sel_i   (bus.Instr_Ry),
        .dbg_sel_i  (bus.Reg_Rd_Sel),
        .rx_data_o  (rx_data),
        .ry_data_o  (ry_data),
        .dbg_data_o (bus.Reg_Rd_Data)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            func_sel_q    <= '0;
            operand_x_q   <= '0;
            operand_y_q   <= '0;
            const_k_q     <= '0;
            rd_q          <= '0;
            status_q      <= '0;
            done_result_q <= '0;
        end else begin
            state_q <= state_d;
            // Read ports see pre-edge contents, so a same-edge load leaves the old operand.
            if (accept) begin
                func_sel_q  <= bus.Instr_Func;
                operand_x_q <= rx_data;
                operand_y_q <= ry_data;
                const_k_q   <= bus.Instr_K;
                rd_q        <= bus.Instr_Rd;
            end
            if (state_q == ST_EXEC) begin
                status_q      <= bus.ALU_CNVZ;
                done_result_q <= bus.ALU_Result;
            end
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = accept ? ST_EXEC : ST_IDLE;
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == ST_IDLE) && !Reset;
        accept      = bus.Instr_Valid && instr_ready;
        done_valid  = (state_q == ST_DONE);
        // Single write port: an external load takes it over the writeback.
        wr_en       = 1'b0;
        wr_addr     = rd_q;
        wr_data     = bus.ALU_Result;
        if (bus.Reg_Load) begin
            wr_en   = 1'b1;
            wr_addr = bus.Reg_Load_Sel;
            wr_data = bus.Reg_Load_Data;
        end else if (state_q == ST_EXEC) begin
            wr_en   = 1'b1;
        end
    end

    assign bus.Instr_Ready = instr_ready;
    assign bus.Done_Valid  = done_valid;
    assign bus.Func_Sel    = func_sel_q;
    assign bus.Operand_X   = operand_x_q;
    assign bus.Operand_Y   = operand_y_q;
    assign bus.Const_K     = const_k_q;
    assign bus.cin         = status_q[CNVZ_C];
    assign bus.Done_Result = done_result_q;
    assign bus.Status_CNVZ = status_q;

endmodule

// File: doc/cjb_alu_ctrl_v.md
# cjb_alu_ctrl_v

Sequencing controller that drives the 8-bit ALU's operand/function inputs and consumes its result and CNVZ flags.
- Accepts one register-to-register instruction at a time over a valid/ready handshake.
- Reads operands from an internal 4×8 register file, presents them to the ALU for one cycle, then writes the result and flags back.
- Sits between the instruction source (decoder/testbench) and the combinational ALU, closing the ALU's input/output interface.

## Interface
- DATA_W, 8, datapath width; fixed at 8 to match the ALU.
- RA_W, 2, register address width (4 registers).

- Clock  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high.
- Instr_Valid  in  1  instruction fields valid.
- Instr_Ready  out  1  controller can accept; `(state==IDLE) & ~Reset`.
- Instr_Func  in  4  ALU function select for this instruction.
- Instr_Rd, Instr_Rx, Instr_Ry  in  RA_W  destination, X source and Y source registers.
- Instr_K  in  2  constant passed to the ALU.
- Reg_Load  in  1  external register write strobe.
- Reg_Load_Sel  in  RA_W  register to load.
- Reg_Load_Data  in  DATA_W  data to load.
- Reg_Rd_Sel  in  RA_W  debug read select.
- Reg_Rd_Data  out  DATA_W  combinational read of `regfile[Reg_Rd_Sel]`.
- Func_Sel  out  4  to ALU; registered.
- Operand_X, Operand_Y  out  DATA_W  to ALU; registered.
- Const_K  out  2  to ALU; registered.
- cin  out  1  to ALU; equals `Status_CNVZ[3]` (C).
- ALU_Result  in  DATA_W  from ALU; combinational.
- ALU_CNVZ  in  4  from ALU; bit order C, N, V, Z (bit 3..0).
- Done_Valid  out  1  one-cycle pulse on completion.
- Done_Result  out  DATA_W  result of the completed instruction; held until the next completion.
- Status_CNVZ  out  4  status register.

## Operation
- FSM states: IDLE, EXEC, DONE (encoding 2'b00, 2'b01, 2'b10; 2'b11 returns to IDLE).
- **IDLE**
  - On `Instr_Valid & Instr_Ready`, capture into flops: `Func_Sel=Instr_Func`, `Operand_X=regfile[Instr_Rx]`, `Operand_Y=regfile[Instr_Ry]`, `Const_K=Instr_K`, `Rd=Instr_Rd`.
  - Next state: EXEC.
- **EXEC**
  - ALU is combinationally valid during this cycle.
  - At the closing edge: `regfile[Rd]<=ALU_Result`, `Status_CNVZ<=ALU_CNVZ`, `Done_Result<=ALU_Result`.
  - Next state: DONE.
- **DONE**
  - `Done_Valid=1` for exactly this cycle.
  - Next state: IDLE.
- Status is written for every function group, including logic, shift/rotate and constant.
- cin is sourced from the status register. Status changes only at the EXEC→DONE edge, so cin is stable throughout EXEC.
- Operands are read at acceptance. Rx==Ry and Rd==Rx are legal; the source value is the pre-instruction value.
- `Reg_Load` is accepted in any state.
  - Same edge as instruction acceptance with `Reg_Load_Sel==Instr_Rx`: the operand captured is the OLD value.
  - Same edge as writeback with the same register: Reg_Load wins.
- Instr_Valid while not ready: ignored; the source must hold its fields until accepted.
- Reset, including mid-instruction:
  - state=IDLE; regfile, Status_CNVZ, Func_Sel, Operand_X/Y, Const_K, Done_Result all = 0; Done_Valid=0.
  - Any in-flight instruction is abandoned with no writeback.

## Timing
- Accept at edge N → EXEC in cycle N+1 → Done_Valid, updated regfile and updated Status_CNVZ visible in cycle N+2 → Instr_Ready=1 in cycle N+3.
- Throughput: one instruction per 3 cycles.
- Instr_Ready is 0 during EXEC and DONE.
- ALU path: registered controller outputs → ALU → regfile/status flops. One full cycle of ALU combinational delay is allowed.
- Reg_Rd_Data reflects a write in the cycle after that write's edge.

## Structure
- Shared include/package `cjb_alu_ctrl_defs`:
  - state encodings;
  - CNVZ bit indices (C=3, N=2, V=1, Z=0);
  - Func_Sel group codes (`[3:2]`: 00 arith, 01 logic, 10 shift/rotate, 11 const).
- Sub-module `cjb_regfile4x8_v`:
  - 4×8 registers;
  - three combinational read ports (X, Y, debug);
  - one write port, with Reg_Load priority muxed in the controller.

## Test plan
- **Reset mid-EXEC.** Assert Reset in EXEC → next cycle state IDLE, Done_Valid=0, Status_CNVZ=0, destination register unchanged (0).
- **Add through the real ALU.** Load R0=8'h7F, R1=8'h01; issue arith add (Func_Sel 4'b0000), Rd=R2 → Done_Valid in cycle N+2; R2=8'h80; CNVZ: C=0, N=1, V=1, Z=0.
- **Carry into cin.** Load R0=8'hFF, R1=8'h01; add into R3 → R3=8'h00, C=1, Z=1. Next instruction: cin=1 throughout its EXEC.
- **Handshake.** Hold Instr_Valid=1 continuously with distinct instructions → acceptances exactly 3 cycles apart; Instr_Ready low in EXEC/DONE; no instruction dropped or duplicated.
- **Load/accept collision.** Reg_Load R0=8'h55 on the same edge as accepting an instruction with Rx=R0 (old R0=8'h10) → Operand_X=8'h10; afterwards Reg_Rd_Data for R0=8'h55.
- **Load/writeback collision.** Reg_Load to Rd on the EXEC→DONE edge → Reg_Load data retained; Done_Result still equals ALU_Result; Status_CNVZ still updated.
